// File: rtl/csp_channel.sv
`timescale 1ns/1ps
// Single-slot CSP channel: one WIDTH-bit token buffered between a bundled-data
// sender and receiver, using either a 4-phase or a 2-phase handshake.
//
//   state  | meaning
//   S_IDLE | sender side waiting for a request while the slot is empty
//   S_RTZ  | token captured, waiting for s_req to return to zero (4-phase only)
//   R_IDLE | nothing offered to the receiver yet
//   R_WAIT | token offered on r_req, waiting for r_ack (also the 2-phase "issued" mark)
//   R_RTZ  | token consumed, waiting for r_ack to return to zero (4-phase only)
module csp_channel #(
    parameter int WIDTH       = 8,
    parameter int HS_PROTOCOL = 0,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_req,
    input  logic [WIDTH-1:0]     s_data,
    output logic                 s_ack,
    output logic                 r_req,
    output logic [WIDTH-1:0]     r_data,
    input  logic                 r_ack,
    output logic                 full,
    output logic                 send_pending,
    output logic [CNT_WIDTH-1:0] xfer_cnt
);

    localparam logic       S_IDLE = 1'b0;
    localparam logic       S_RTZ  = 1'b1;
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_RTZ  = 2'd2;

    logic             sState;
    logic [1:0]       rState;
    logic [WIDTH-1:0] slot;
    logic             sendReq;

    // A new request is a level in 4-phase and a req/ack disagreement in 2-phase.
    assign sendReq      = (HS_PROTOCOL != 0) ? (s_req ^ s_ack) : (s_req && (sState == S_IDLE));
    assign send_pending = sendReq && full;
    assign r_data       = slot;

    always_ff @(posedge clk) begin
        if (reset) begin
            sState   <= S_IDLE;
            rState   <= R_IDLE;
            slot     <= '0;
            full     <= 1'b0;
            s_ack    <= 1'b0;
            r_req    <= 1'b0;
            xfer_cnt <= '0;
        end else if (HS_PROTOCOL == 0) begin
            case (sState)
                S_IDLE: if (s_req && !full) begin
                    slot   <= s_data;
                    full   <= 1'b1;
                    s_ack  <= 1'b1;
                    sState <= S_RTZ;
                end
                S_RTZ: if (!s_req) begin
                    s_ack  <= 1'b0;
                    sState <= S_IDLE;
                end
                default: sState <= S_IDLE;
            endcase

            case (rState)
                R_IDLE: if (full) begin
                    r_req  <= 1'b1;
                    rState <= R_WAIT;
                end
                R_WAIT: if (r_ack) begin
                    r_req    <= 1'b0;
                    full     <= 1'b0;
                    xfer_cnt <= xfer_cnt + CNT_WIDTH'(1);
                    rState   <= R_RTZ;
                end
                R_RTZ: if (!r_ack) begin
                    rState <= R_IDLE;
                end
                default: rState <= R_IDLE;
            endcase
        end else begin
            if (sendReq && !full) begin
                slot  <= s_data;
                full  <= 1'b1;
                s_ack <= s_req;
            end

            case (rState)
                R_IDLE: if (full && (r_req == r_ack)) begin
                    r_req  <= ~r_req;
                    rState <= R_WAIT;
                end
                R_WAIT: if (r_ack == r_req) begin
                    full     <= 1'b0;
                    xfer_cnt <= xfer_cnt + CNT_WIDTH'(1);
                    rState   <= R_IDLE;
                end
                default: rState <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csp_channel.sv
`timescale 1ns/1ps
// Bench for csp_channel: directed handshake scenarios on a 4-phase (4-bit counter)
// and a 2-phase instance, then random traffic against a token-queue reference.
module tb_csp_channel;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       s4Req, s4Ack, r4Req, r4Ack, full4, pend4;
    logic [7:0] s4Data, r4Data;
    logic [3:0] cnt4;
    logic       s2Req, s2Ack, r2Req, r2Ack, full2, pend2;
    logic [7:0] s2Data, r2Data;
    logic [15:0] cnt2;

    int errors = 0;
    int checks = 0;
    logic [7:0] q4[$];
    logic [7:0] q2[$];
    int expCnt4, expCnt2;
    logic expAck2;
    logic stopNew;
    logic [7:0] tok;

    csp_channel #(.WIDTH(8), .HS_PROTOCOL(0), .CNT_WIDTH(4)) u4 (
        .clk(clk), .reset(reset), .s_req(s4Req), .s_data(s4Data), .s_ack(s4Ack),
        .r_req(r4Req), .r_data(r4Data), .r_ack(r4Ack), .full(full4),
        .send_pending(pend4), .xfer_cnt(cnt4));

    csp_channel #(.WIDTH(8), .HS_PROTOCOL(1), .CNT_WIDTH(16)) u2 (
        .clk(clk), .reset(reset), .s_req(s2Req), .s_data(s2Data), .s_ack(s2Ack),
        .r_req(r2Req), .r_data(r2Data), .r_ack(r2Ack), .full(full2),
        .send_pending(pend2), .xfer_cnt(cnt2));

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input logic [7:0] d);
        int n;
        n = 0;
        s4Data = d;
        s4Req  = 1'b1;
        do begin
            tick();
            n++;
        end while (!s4Ack && n < 50);
        checkVal("send4 ack", s4Ack, 1);
        s4Req = 1'b0;
        tick();
        checkVal("send4 ack rtz", s4Ack, 0);
    endtask

    task automatic recv4(input logic [7:0] exp);
        int n;
        n = 0;
        while (!r4Req && n < 50) begin
            tick();
            n++;
        end
        checkVal("recv4 req", r4Req, 1);
        checkVal("recv4 data", r4Data, exp);
        r4Ack = 1'b1;
        tick();
        checkVal("recv4 req low", r4Req, 0);
        checkVal("recv4 full low", full4, 0);
        r4Ack = 1'b0;
        tick();
    endtask

    task automatic applyReset();
        reset = 1'b1;
        s4Req = 1'b0; r4Ack = 1'b0; s2Req = 1'b0; r2Ack = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        s4Req = 1'b0; r4Ack = 1'b0; s4Data = 8'h00;
        s2Req = 1'b0; r2Ack = 1'b0; s2Data = 8'h00;
        tick();
        tick();
        checkVal("rst s_ack4", s4Ack, 0);
        checkVal("rst r_req4", r4Req, 0);
        checkVal("rst r_data4", r4Data, 0);
        checkVal("rst full4", full4, 0);
        checkVal("rst cnt4", cnt4, 0);
        checkVal("rst s_ack2", s2Ack, 0);
        checkVal("rst r_req2", r2Req, 0);
        checkVal("rst full2", full2, 0);
        checkVal("rst cnt2", cnt2, 0);
        reset = 1'b0;

        // 4-phase single transfer with latency
        s4Data = 8'hA5;
        s4Req  = 1'b1;
        tick();
        checkVal("p4 s_ack after N", s4Ack, 1);
        checkVal("p4 full after N", full4, 1);
        checkVal("p4 r_req not yet", r4Req, 0);
        tick();
        checkVal("p4 r_req after N+1", r4Req, 1);
        checkVal("p4 r_data", r4Data, 8'hA5);
        r4Ack = 1'b1;
        tick();
        checkVal("p4 r_req after ack", r4Req, 0);
        checkVal("p4 full after ack", full4, 0);
        checkVal("p4 cnt=1", cnt4, 1);
        s4Req = 1'b0;
        r4Ack = 1'b0;
        tick();
        checkVal("p4 s_ack rtz", s4Ack, 0);
        checkVal("p4 r_req idle", r4Req, 0);
        checkVal("p4 full idle", full4, 0);

        // backpressure
        send4(8'h11);
        checkVal("bp r_req up", r4Req, 1);
        s4Data = 8'h22;
        s4Req  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkVal("bp s_ack blocked", s4Ack, 0);
            checkVal("bp send_pending", pend4, 1);
            checkVal("bp r_data held", r4Data, 8'h11);
        end
        r4Ack = 1'b1;
        tick();
        checkVal("bp free full", full4, 0);
        checkVal("bp free r_req", r4Req, 0);
        checkVal("bp no capture yet", s4Ack, 0);
        checkVal("bp pending clear", pend4, 0);
        checkVal("bp cnt=2", cnt4, 2);
        r4Ack = 1'b0;
        tick();
        checkVal("bp capture ack", s4Ack, 1);
        checkVal("bp capture full", full4, 1);
        checkVal("bp capture data", r4Data, 8'h22);
        s4Req = 1'b0;
        tick();
        recv4(8'h22);
        checkVal("bp cnt=3", cnt4, 3);

        // data stability while s_data wanders with no request
        send4(8'h3C);
        for (int i = 0; i < 6; i++) begin
            s4Data = 8'($urandom);
            tick();
            checkVal("stab r_data", r4Data, 8'h3C);
        end
        recv4(8'h3C);
        s4Data = 8'hC3;
        tick();
        checkVal("stab after free", r4Data, 8'h3C);
        checkVal("stab cnt=4", cnt4, 4);

        // reset mid-transfer
        send4(8'h77);
        checkVal("mid r_req", r4Req, 1);
        checkVal("mid full", full4, 1);
        applyReset();
        checkVal("mid rst r_req", r4Req, 0);
        checkVal("mid rst s_ack", s4Ack, 0);
        checkVal("mid rst full", full4, 0);
        checkVal("mid rst r_data", r4Data, 0);
        checkVal("mid rst cnt", cnt4, 0);
        send4(8'h5A);
        recv4(8'h5A);
        checkVal("post rst cnt", cnt4, 1);

        // counter wrap on the 4-bit instance
        applyReset();
        for (int i = 0; i < 17; i++) begin
            tok = 8'($urandom);
            send4(tok);
            recv4(tok);
        end
        checkVal("wrap cnt", cnt4, 1);

        // 2-phase: three tokens in order
        expAck2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tok     = 8'(k + 1);
            s2Data  = tok;
            s2Req   = ~s2Req;
            expAck2 = ~expAck2;
            tick();
            checkVal("p2 s_ack toggle", s2Ack, expAck2);
            checkVal("p2 full", full2, 1);
            tick();
            checkVal("p2 r_req toggle", r2Req, expAck2);
            checkVal("p2 r_data", r2Data, tok);
            r2Ack = r2Req;
            tick();
            checkVal("p2 free", full2, 0);
            checkVal("p2 cnt", cnt2, k + 1);
        end
        checkVal("p2 cnt=3", cnt2, 3);

        // 2-phase backpressure
        s2Data = 8'h44;
        s2Req  = ~s2Req;
        tick();
        s2Data = 8'h55;
        s2Req  = ~s2Req;
        tick();
        checkVal("p2 bp pending", pend2, 1);
        checkVal("p2 bp ack held", s2Ack == s2Req, 0);
        checkVal("p2 bp data", r2Data, 8'h44);
        checkVal("p2 bp r_req out", r2Req != r2Ack, 1);
        r2Ack = r2Req;
        tick();
        checkVal("p2 bp free", full2, 0);
        tick();
        checkVal("p2 bp capture", s2Ack == s2Req, 1);
        checkVal("p2 bp data2", r2Data, 8'h55);
        tick();
        r2Ack = r2Req;
        tick();
        checkVal("p2 bp cnt", cnt2, 5);

        // random traffic on both instances against token queues
        applyReset();
        q4.delete();
        q2.delete();
        expCnt4 = 0;
        expCnt2 = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            stopNew = (cyc >= 1600);
            if (!s4Req && !s4Ack) begin
                if (!stopNew && $urandom_range(0, 2) == 0) begin
                    s4Data = 8'($urandom);
                    s4Req  = 1'b1;
                    q4.push_back(s4Data);
                end else begin
                    s4Data = 8'($urandom);
                end
            end else if (s4Req && s4Ack && $urandom_range(0, 1) == 0) begin
                s4Req = 1'b0;
            end
            if (r4Req && !r4Ack) begin
                if (q4.size() == 0) begin
                    checkVal("rnd4 unexpected token", 1, 0);
                end else begin
                    checkVal("rnd4 data", r4Data, q4[0]);
                    if ($urandom_range(0, 2) == 0) begin
                        r4Ack = 1'b1;
                        void'(q4.pop_front());
                        expCnt4++;
                    end
                end
            end else if (!r4Req && r4Ack && $urandom_range(0, 1) == 0) begin
                r4Ack = 1'b0;
            end

            if (s2Req == s2Ack) begin
                s2Data = 8'($urandom);
                if (!stopNew && $urandom_range(0, 2) == 0) begin
                    s2Req = ~s2Req;
                    q2.push_back(s2Data);
                end
            end
            if (r2Req != r2Ack) begin
                if (q2.size() == 0) begin
                    checkVal("rnd2 unexpected token", 1, 0);
                end else begin
                    checkVal("rnd2 data", r2Data, q2[0]);
                    if ($urandom_range(0, 2) == 0) begin
                        r2Ack = r2Req;
                        void'(q2.pop_front());
                        expCnt2++;
                    end
                end
            end

            tick();
            checkVal("rnd4 cnt", cnt4, expCnt4 % 16);
            checkVal("rnd2 cnt", cnt2, expCnt2 % 65536);
        end
        checkVal("rnd4 drained", q4.size(), 0);
        checkVal("rnd2 drained", q2.size(), 0);
        checkVal("rnd4 idle", full4, 0);
        checkVal("rnd2 idle", full2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
